// File: rtl/rib_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : rib_arbiter_if
//  Description : Signal bundle for rib_arbiter. Carries the three master
//                request/response channels (m0 = execute load/store,
//                m1 = debug, m2 = instruction fetch), the single slave
//                channel, and the pipeline stall / timeout indications.
//  Modports    : slave  - arbiter view (receives master requests, drives
//                         the slave bus, hold_o and err_o)
//                master - environment view (drives master requests and
//                         slave responses)
//  Revision    : 1.0 - initial release
// ============================================================================
interface rib_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // master 0 : execute load/store
    logic              m0_req_i;
    logic              m0_we_i;
    logic [ADDR_W-1:0] m0_addr_i;
    logic [DATA_W-1:0] m0_wdata_i;
    logic [DATA_W-1:0] m0_rdata_o;
    logic              m0_ack_o;
    // master 1 : debug
    logic              m1_req_i;
    logic              m1_we_i;
    logic [ADDR_W-1:0] m1_addr_i;
    logic [DATA_W-1:0] m1_wdata_i;
    logic [DATA_W-1:0] m1_rdata_o;
    logic              m1_ack_o;
    // master 2 : instruction fetch
    logic              m2_req_i;
    logic              m2_we_i;
    logic [ADDR_W-1:0] m2_addr_i;
    logic [DATA_W-1:0] m2_wdata_i;
    logic [DATA_W-1:0] m2_rdata_o;
    logic              m2_ack_o;
    // slave channel
    logic              s_req_o;
    logic              s_we_o;
    logic [ADDR_W-1:0] s_addr_o;
    logic [DATA_W-1:0] s_wdata_o;
    logic [DATA_W-1:0] s_rdata_i;
    logic              s_ack_i;
    // pipeline / status
    logic              hold_o;
    logic              err_o;

    modport slave (
        input  m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
        input  m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
        input  m2_req_i, m2_we_i, m2_addr_i, m2_wdata_i,
        output m0_rdata_o, m0_ack_o, m1_rdata_o, m1_ack_o, m2_rdata_o, m2_ack_o,
        output s_req_o, s_we_o, s_addr_o, s_wdata_o,
        input  s_rdata_i, s_ack_i,
        output hold_o, err_o
    );

    modport master (
        output m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
        output m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
        output m2_req_i, m2_we_i, m2_addr_i, m2_wdata_i,
        input  m0_rdata_o, m0_ack_o, m1_rdata_o, m1_ack_o, m2_rdata_o, m2_ack_o,
        input  s_req_o, s_we_o, s_addr_o, s_wdata_o,
        output s_rdata_i, s_ack_i,
        input  hold_o, err_o
    );
endinterface
`default_nettype wire

// File: rtl/rib_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rib_arbiter
//  Description : Three-master / single-slave arbiter for the shared memory
//                bus. One transaction in flight; fixed priority m0 > m1 > m2
//                with a starvation guard that forces a fetch (m2) grant after
//                STARVE_LIM consecutive non-fetch grants while m2 waits.
//                A transaction with no slave ack for TIMEOUT cycles is
//                terminated with a zero-data ack and a one-cycle err_o pulse.
//  Ports       : clk  - clock
//                rst  - asynchronous reset, active-low
//                bus  - rib_arbiter_if.slave (master channels, slave channel,
//                       hold_o stall request, err_o timeout pulse)
//  Revision    : 1.0 - initial release
// ============================================================================
module rib_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_LIM = 4,
    parameter int TIMEOUT    = 16
) (
    input  wire logic     clk,
    input  wire logic     rst,
    rib_arbiter_if.slave  bus
);
    localparam int c_SC_W = $clog2(STARVE_LIM + 1);
    localparam int c_TO_W = $clog2(TIMEOUT);

    localparam logic [c_SC_W-1:0] c_STARVE_MAX = c_SC_W'(STARVE_LIM);
    localparam logic [c_TO_W-1:0] c_TO_LAST    = c_TO_W'(TIMEOUT - 1);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_BUSY = 1'b1;

    logic [0:0]        r_state;
    logic [1:0]        r_gnt;
    logic [c_SC_W-1:0] r_starve_cnt;
    logic [c_TO_W-1:0] r_to_cnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    logic              w_busy;
    logic              w_any_req;
    logic [1:0]        w_win;
    logic              w_win_we;
    logic [ADDR_W-1:0] w_win_addr;
    logic [DATA_W-1:0] w_win_wdata;
    logic              w_slv_ack;
    logic              w_timeout;
    logic              w_done;
    logic [DATA_W-1:0] w_rdata;
    logic [2:0]        w_ack;

    assign w_busy    = (r_state == c_BUSY);
    assign w_any_req = bus.m0_req_i | bus.m1_req_i | bus.m2_req_i;

    // Winner selection; only meaningful while IDLE with a request present.
    always_comb begin
        w_win = 2'd0;
        if (bus.m2_req_i && (r_starve_cnt >= c_STARVE_MAX)) begin
            w_win = 2'd2;
        end else if (bus.m0_req_i) begin
            w_win = 2'd0;
        end else if (bus.m1_req_i) begin
            w_win = 2'd1;
        end else if (bus.m2_req_i) begin
            w_win = 2'd2;
        end
    end

    always_comb begin
        w_win_we    = bus.m0_we_i;
        w_win_addr  = bus.m0_addr_i;
        w_win_wdata = bus.m0_wdata_i;
        case (w_win)
            2'd1: begin
                w_win_we    = bus.m1_we_i;
                w_win_addr  = bus.m1_addr_i;
                w_win_wdata = bus.m1_wdata_i;
            end
            2'd2: begin
                w_win_we    = bus.m2_we_i;
                w_win_addr  = bus.m2_addr_i;
                w_win_wdata = bus.m2_wdata_i;
            end
            default: ;
        endcase
    end

    // A slave ack in the final timeout cycle wins over the timeout.
    assign w_slv_ack = w_busy & bus.s_ack_i;
    assign w_timeout = w_busy & ~bus.s_ack_i & (r_to_cnt == c_TO_LAST);
    assign w_done    = w_slv_ack | w_timeout;
    assign w_rdata   = w_slv_ack ? bus.s_rdata_i : '0;

    assign w_ack[0] = w_done & (r_gnt == 2'd0);
    assign w_ack[1] = w_done & (r_gnt == 2'd1);
    assign w_ack[2] = w_done & (r_gnt == 2'd2);

    assign bus.m0_ack_o   = w_ack[0];
    assign bus.m1_ack_o   = w_ack[1];
    assign bus.m2_ack_o   = w_ack[2];
    assign bus.m0_rdata_o = w_ack[0] ? w_rdata : '0;
    assign bus.m1_rdata_o = w_ack[1] ? w_rdata : '0;
    assign bus.m2_rdata_o = w_ack[2] ? w_rdata : '0;
    assign bus.err_o      = w_timeout;

    assign bus.s_req_o   = w_busy;
    assign bus.s_we_o    = w_busy & r_we;
    assign bus.s_addr_o  = w_busy ? r_addr  : '0;
    assign bus.s_wdata_o = w_busy ? r_wdata : '0;

    // Gated by rst so the stall request is also silent while in reset.
    assign bus.hold_o = rst & ((bus.m0_req_i & ~w_ack[0]) |
                               (bus.m2_req_i & ~w_ack[2]));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= c_IDLE;
            r_gnt    <= 2'd0;
            r_to_cnt <= '0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_any_req) begin
                        r_state  <= c_BUSY;
                        r_gnt    <= w_win;
                        r_to_cnt <= '0;
                        r_we     <= w_win_we;
                        r_addr   <= w_win_addr;
                        r_wdata  <= w_win_wdata;
                    end
                end
                c_BUSY: begin
                    if (w_done) begin
                        r_state <= c_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + c_TO_W'(1);
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Counts consecutive m0/m1 grants taken while fetch was waiting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_starve_cnt <= '0;
        end else if (!bus.m2_req_i) begin
            r_starve_cnt <= '0;
        end else if (!w_busy && w_any_req) begin
            if (w_win == 2'd2) begin
                r_starve_cnt <= '0;
            end else if (r_starve_cnt < c_STARVE_MAX) begin
                r_starve_cnt <= r_starve_cnt + c_SC_W'(1);
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_rib_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rib_arbiter
//  Description : Self-checking bench for rib_arbiter. Directed scenarios
//                followed by randomized master/slave traffic, all checked
//                cycle by cycle against a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rib_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SL = 4;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rib_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    rib_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIM(SL), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // stimulus
    logic        t_req[3];
    logic        t_we[3];
    logic [31:0] t_addr[3];
    logic [31:0] t_wdata[3];
    logic        t_sack;
    logic [31:0] t_srdata;

    assign bus.m0_req_i   = t_req[0];
    assign bus.m0_we_i    = t_we[0];
    assign bus.m0_addr_i  = t_addr[0];
    assign bus.m0_wdata_i = t_wdata[0];
    assign bus.m1_req_i   = t_req[1];
    assign bus.m1_we_i    = t_we[1];
    assign bus.m1_addr_i  = t_addr[1];
    assign bus.m1_wdata_i = t_wdata[1];
    assign bus.m2_req_i   = t_req[2];
    assign bus.m2_we_i    = t_we[2];
    assign bus.m2_addr_i  = t_addr[2];
    assign bus.m2_wdata_i = t_wdata[2];
    assign bus.s_ack_i    = t_sack;
    assign bus.s_rdata_i  = t_srdata;

    int vectors     = 0;
    int miscompares = 0;

    // reference model: one transaction owner, its age, fetch-skip tally
    bit          m_busy  = 0;
    int          m_owner = 0;
    int          m_wait  = 0;
    int          m_skip  = 0;
    logic        m_we    = 1'b0;
    logic [31:0] m_addr  = '0;
    logic [31:0] m_wdata = '0;

    // expected acks of the last step, and observed values of the last step
    logic        e_ack[3];
    logic        l_ack[3];
    logic [31:0] l_rd[3];
    logic        l_sreq, l_we, l_hold, l_err;
    logic [31:0] l_addr, l_wdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check outputs mid-cycle, then advance the model.
    task automatic step();
        logic        ex_ack[3];
        logic [31:0] ex_rd[3];
        logic        ex_sreq, ex_err, ex_hold;
        bit          dack, dto, any;
        int          win;
        @(negedge clk);
        #1;
        l_ack[0] = bus.m0_ack_o;   l_ack[1] = bus.m1_ack_o;   l_ack[2] = bus.m2_ack_o;
        l_rd[0]  = bus.m0_rdata_o; l_rd[1]  = bus.m1_rdata_o; l_rd[2]  = bus.m2_rdata_o;
        l_sreq = bus.s_req_o;  l_we = bus.s_we_o;  l_addr = bus.s_addr_o;
        l_wdata = bus.s_wdata_o; l_hold = bus.hold_o; l_err = bus.err_o;

        dack    = rst && m_busy && t_sack;
        dto     = rst && m_busy && !t_sack && (m_wait == TO - 1);
        ex_sreq = rst && m_busy;
        ex_err  = dto;
        for (int n = 0; n < 3; n++) begin
            ex_ack[n] = (dack || dto) && (m_owner == n);
            ex_rd[n]  = (ex_ack[n] && dack) ? t_srdata : 32'h0;
        end
        ex_hold = rst && ((t_req[0] && !ex_ack[0]) || (t_req[2] && !ex_ack[2]));

        chk("s_req", l_sreq, ex_sreq);
        chk("err", l_err, ex_err);
        chk("hold", l_hold, ex_hold);
        for (int n = 0; n < 3; n++) begin
            chk($sformatf("ack%0d", n), l_ack[n], ex_ack[n]);
            chk($sformatf("rdata%0d", n), l_rd[n], ex_rd[n]);
        end
        if (ex_sreq) begin
            chk("s_we", l_we, m_we);
            chk("s_addr", l_addr, m_addr);
            chk("s_wdata", l_wdata, m_wdata);
        end
        e_ack = ex_ack;

        @(posedge clk);
        if (!rst) begin
            m_busy = 0; m_wait = 0; m_skip = 0; m_owner = 0;
        end else begin
            any = t_req[0] || t_req[1] || t_req[2];
            win = (t_req[2] && m_skip >= SL) ? 2 : t_req[0] ? 0 : t_req[1] ? 1 : 2;
            if (!t_req[2])
                m_skip = 0;
            else if (!m_busy && any)
                m_skip = (win == 2) ? 0 : ((m_skip + 1 > SL) ? SL : m_skip + 1);
            if (m_busy) begin
                if (dack || dto) m_busy = 0;
                else             m_wait++;
            end else if (any) begin
                m_busy = 1; m_owner = win; m_wait = 0;
                m_we = t_we[win]; m_addr = t_addr[win]; m_wdata = t_wdata[win];
            end
        end
        #1;
    endtask

    task automatic idle_all();
        for (int n = 0; n < 3; n++) begin
            t_req[n] = 1'b0; t_we[n] = 1'b0; t_addr[n] = '0; t_wdata[n] = '0;
        end
        t_sack = 1'b0;
        t_srdata = '0;
    endtask

    task automatic rnd_cycle(input int pct);
        for (int n = 0; n < 3; n++) begin
            if (!t_req[n] || e_ack[n]) begin
                if ($urandom_range(0, 2) != 0) begin
                    t_req[n] = 1'b1; t_we[n] = 1'($urandom_range(0, 1));
                    t_addr[n] = $urandom; t_wdata[n] = $urandom;
                end else begin
                    t_req[n] = 1'b0;
                end
            end
        end
        t_sack   = (int'($urandom_range(0, 99)) < pct);
        t_srdata = $urandom;
        step();
    endtask

    initial begin : watchdog
        #1ms;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int a0, a2, nb;
        bit found;
        int owners[$];
        int pcts[4] = '{0, 10, 50, 100};
        for (int n = 0; n < 3; n++) e_ack[n] = 1'b0;
        idle_all();

        // reset state
        t_req[0] = 1'b1;
        step(); step();
        chk("rst_hold", l_hold, 1'b0);
        t_req[0] = 1'b0;
        rst = 1'b1;
        step();
        chk("post_rst_sreq", l_sreq, 1'b0);

        // m0 single read, zero-wait slave
        t_req[0] = 1'b1; t_we[0] = 1'b0; t_addr[0] = 32'h100;
        step();
        chk("rd_hold_T", l_hold, 1'b1);
        chk("rd_sreq_T", l_sreq, 1'b0);
        t_sack = 1'b1; t_srdata = 32'hCAFEF00D;
        step();
        chk("rd_sreq_T1", l_sreq, 1'b1);
        chk("rd_ack_T1", l_ack[0], 1'b1);
        chk("rd_data_T1", l_rd[0], 32'hCAFEF00D);
        chk("rd_addr_T1", l_addr, 32'h100);
        chk("rd_hold_T1", l_hold, 1'b0);
        t_req[0] = 1'b0; t_sack = 1'b0;
        step();
        chk("rd_sreq_T2", l_sreq, 1'b0);

        // simultaneous m0 and m2, two wait states
        t_req[0] = 1'b1; t_addr[0] = 32'h200;
        t_req[2] = 1'b1; t_addr[2] = 32'h300;
        a0 = -1; a2 = -1;
        for (int c = 0; c < 20 && a2 < 0; c++) begin
            for (int n = 0; n < 3; n++) if (e_ack[n]) t_req[n] = 1'b0;
            t_sack = m_busy && (m_wait == 2);
            t_srdata = $urandom;
            step();
            if (l_ack[0]) a0 = c;
            if (l_ack[2]) a2 = c;
            if (a2 < 0) chk("sim_hold", l_hold, 1'b1);
        end
        chk("sim_m0_ack_cyc", a0, 3);
        chk("sim_m2_ack_cyc", a2, 7);
        t_req[2] = 1'b0; t_sack = 1'b0;
        step();

        // m1 write while m0 wiggles its (non-requesting) inputs
        t_req[1] = 1'b1; t_we[1] = 1'b1; t_addr[1] = 32'h20; t_wdata[1] = 32'h12345678;
        found = 0;
        for (int c = 0; c < 12 && !found; c++) begin
            t_req[0] = 1'b0; t_we[0] = 1'($urandom_range(0, 1));
            t_addr[0] = $urandom; t_wdata[0] = $urandom;
            t_sack = m_busy && (m_wait == 3);
            step();
            chk("wr_hold", l_hold, 1'b0);
            if (l_sreq) begin
                chk("wr_we", l_we, 1'b1);
                chk("wr_addr", l_addr, 32'h20);
                chk("wr_wdata", l_wdata, 32'h12345678);
            end
            if (l_ack[1]) found = 1;
        end
        chk("wr_done", found, 1'b1);
        idle_all();
        step();

        // starvation guard
        t_req[0] = 1'b1; t_addr[0] = 32'h400;
        t_req[2] = 1'b1; t_addr[2] = 32'h500;
        t_sack = 1'b1;
        for (int c = 0; c < 14; c++) begin
            step();
            for (int n = 0; n < 3; n++) if (l_ack[n]) owners.push_back(n);
        end
        chk("stv_count", owners.size(), 7);
        if (owners.size() >= 6) begin
            for (int k = 0; k < 6; k++)
                chk($sformatf("stv_owner%0d", k), owners[k], (k == 4) ? 2 : 0);
        end
        idle_all();
        step();

        // timeout, then a late ack
        t_req[0] = 1'b1; t_addr[0] = 32'h600;
        nb = 0; found = 0;
        for (int c = 0; c < 40 && !found; c++) begin
            t_srdata = $urandom;
            step();
            if (l_sreq) nb++;
            if (l_err) begin
                found = 1;
                chk("to_cycle", nb, TO);
                chk("to_ack", l_ack[0], 1'b1);
                chk("to_rdata", l_rd[0], 32'h0);
            end
        end
        chk("to_seen", found, 1'b1);
        t_req[0] = 1'b0; t_sack = 1'b1; t_srdata = 32'hDEADBEEF;
        step();
        chk("late_ack", l_ack[0], 1'b0);
        chk("late_err", l_err, 1'b0);
        chk("late_rdata", l_rd[0], 32'h0);
        t_sack = 1'b0;
        step();

        // reset in the 2nd BUSY cycle
        t_req[0] = 1'b1; t_addr[0] = 32'h700;
        step(); step();
        rst = 1'b0;
        step();
        chk("mid_rst_sreq", l_sreq, 1'b0);
        chk("mid_rst_ack", l_ack[0], 1'b0);
        chk("mid_rst_hold", l_hold, 1'b0);
        idle_all();
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("after_rst_sreq", l_sreq, 1'b0);
        end

        // randomized traffic with varying slave responsiveness
        for (int b = 0; b < 40; b++) begin
            int pct;
            pct = pcts[$urandom_range(0, 3)];
            for (int c = 0; c < 50; c++) rnd_cycle(pct);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
